// File: rtl/param_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : param_serializer
//  Description : FIFO-buffered parallel-to-serial framer. Each frame is a start
//                bit, DATA_W data bits, an optional even-parity bit and a stop bit.
//  Revision    : 1.0
// ============================================================================
module param_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frames_sent
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] c_last_bit  = CW'(DATA_W - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);
    localparam logic          c_parity_en = (PARITY_EN != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [CW-1:0]     r_bitcnt;
    logic              r_ser;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_frames;

    logic              w_push;
    logic              w_pop;
    logic              w_head_bit;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_shifted;

    // Readiness depends only on stored occupancy, never on this cycle's pop.
    assign in_ready = !rst && (r_count != c_depth);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && ((r_state == S_IDLE) || (r_state == S_STOP));
    assign w_head   = r_mem[r_rd_ptr];

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_head_bit = r_shift[0];
            assign w_shifted  = {1'b0, r_shift[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_head_bit = r_shift[DATA_W-1];
            assign w_shifted  = {r_shift[DATA_W-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_bitcnt <= '0;
            r_ser    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_frames <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state  <= S_START;
                        r_shift  <= w_head;
                        r_parity <= ^w_head;
                        r_ser    <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    r_state  <= S_DATA;
                    r_bitcnt <= '0;
                    r_ser    <= w_head_bit;
                    r_shift  <= w_shifted;
                end
                S_DATA: begin
                    if (r_bitcnt == c_last_bit) begin
                        if (c_parity_en) begin
                            r_state <= S_PARITY;
                            r_ser   <= r_parity;
                        end else begin
                            r_state <= S_STOP;
                            r_ser   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + CW'(1);
                        r_ser    <= w_head_bit;
                        r_shift  <= w_shifted;
                    end
                end
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_ser   <= 1'b1;
                    r_done  <= 1'b1;
                end
                S_STOP: begin
                    r_done   <= 1'b0;
                    r_frames <= r_frames + 16'd1;
                    // Next queued word starts immediately so frames run back to back.
                    if (w_pop) begin
                        r_state  <= S_START;
                        r_shift  <= w_head;
                        r_parity <= ^w_head;
                        r_ser    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_ser   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ser   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out     = r_ser;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 Parameter DATA_W, default 8, parallel word width (>=2).
REQ-002 Parameter DEPTH, default 4, input FIFO depth in words (power of 2, >=2).
REQ-003 Parameter LSB_FIRST, default 0, 0 = MSB shifted first, 1 = LSB first.
REQ-004 Parameter PARITY_EN, default 1, 1 = append even-parity bit after data bits.
REQ-005 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  producer offers in_data this cycle.
REQ-009 in_ready  output  1  FIFO can accept a word this cycle.
REQ-010 in_data  input  DATA_W  parallel word.
REQ-011 ser_out  output  1  registered serial line, idles high.
REQ-012 busy  output  1  high while a frame is on the line (START..STOP).
REQ-013 frame_done  output  1  one-cycle pulse during the STOP-bit cycle.
REQ-014 frames_sent  output  16  count of completed frames, wraps.

Function
REQ-015 Push occurs on an edge where in_valid && in_ready; in_ready = !full, derived from registered occupancy only (no same-cycle pass-through).
REQ-016 FIFO full: in_ready=0, in_data ignored, no overwrite; FIFO empty: no pop.
REQ-017 FSM states IDLE, START, DATA, PARITY, STOP; ser_out per state: IDLE=1, START=0, DATA=current data bit, PARITY=XOR of word, STOP=1.
REQ-018 IDLE -> START on edge where FIFO non-empty; same edge pops head into shift register.
REQ-019 START -> DATA after 1 cycle; DATA lasts exactly DATA_W cycles via bit counter 0..DATA_W-1.
REQ-020 DATA -> PARITY if PARITY_EN=1, else DATA -> STOP; PARITY lasts 1 cycle then -> STOP.
REQ-021 STOP lasts 1 cycle; then START (popping next word same edge) if FIFO non-empty, else IDLE: back-to-back frames with no idle gap.
REQ-022 Frame length = DATA_W + 2 + PARITY_EN cycles exactly.
REQ-023 Latency: word pushed at edge k into empty FIFO with FSM in IDLE -> start bit on ser_out in cycle after edge k+1.
REQ-024 LSB_FIRST=0 sends bit DATA_W-1 first; LSB_FIRST=1 sends bit 0 first.
REQ-025 Parity bit = even parity: XOR of all DATA_W bits of the word being sent.
REQ-026 Push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-027 frame_done high exactly during STOP cycle; frames_sent increments on STOP->next edge, 0xFFFF wraps to 0x0000.
REQ-028 busy high in START, DATA, PARITY, STOP; low in IDLE.

Reset
REQ-029 On edge with rst=1: state IDLE, FIFO emptied, ser_out=1, busy=0, frame_done=0, frames_sent=0, bit counter 0.
REQ-030 in_ready=0 while rst is high; 1 on first cycle after rst deasserts.
REQ-031 rst mid-frame aborts the frame immediately: ser_out=1 from next cycle, partial frame not counted, queued words discarded.

Verification
REQ-032 DATA_W=8, LSB_FIRST=0, PARITY_EN=1, push 0xA5 -> ser_out 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), frame_done once, frames_sent=1.
REQ-033 LSB_FIRST=1, PARITY_EN=1, push 0x01 -> ser_out 0,1,0,0,0,0,0,0,0,1,1; PARITY_EN=0 push 0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1.
REQ-034 DEPTH=4, hold in_valid with 6 words 0x10..0x15 while idle -> in_ready drops when 4 queued, all 6 words sent in order, frames contiguous (STOP followed directly by START), frames_sent=6.
REQ-035 Assert rst for 1 cycle during DATA bit 3 of a frame with 2 words queued -> ser_out=1, busy=0, frames_sent=0, no further frames without new pushes.
REQ-036 Preload frames_sent to 0xFFFF via 65535 PARITY_EN=0 DATA_W=2 frames, send one more -> frames_sent=0x0000, frame_done pulse still issued.
